// File: rtl/score_keeper.sv
// score_keeper: Pong match controller - scores, post-point freeze, win detect and winner blink
module score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       point_left,
  input  logic       point_right,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       show_left,
  output logic       show_right,
  output logic       play_en,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner
);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [7:0] PF  = 8'(PAUSE_FRAMES);
  localparam logic [7:0] BF  = 8'(BLINK_FRAMES);
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_t;
  state_t state, state_d;
  logic [3:0] sl_d, sr_d;
  logic [7:0] pcnt, pcnt_d, bcnt, bcnt_d;
  logic blink, blink_d, start_q, serve_d, win_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      score_left  <= '0;
      score_right <= '0;
      pcnt        <= '0;
      bcnt        <= '0;
      blink       <= 1'b1;
      start_q     <= 1'b0;
      serve_dir   <= 1'b0;
      winner      <= 1'b0;
      play_en     <= 1'b0;
      game_over   <= 1'b0;
      show_left   <= 1'b1;
      show_right  <= 1'b1;
    end else begin
      state       <= state_d;
      score_left  <= sl_d;
      score_right <= sr_d;
      pcnt        <= pcnt_d;
      bcnt        <= bcnt_d;
      blink       <= blink_d;
      start_q     <= start;
      serve_dir   <= serve_d;
      winner      <= win_d;
      play_en     <= state_d == PLAY;
      game_over   <= state_d == OVER;
      show_left   <= !(state_d == OVER && !win_d) || blink_d;
      show_right  <= !(state_d == OVER && win_d) || blink_d;
    end
  end
  always_comb begin
    state_d = state;
    sl_d    = score_left;
    sr_d    = score_right;
    pcnt_d  = pcnt;
    bcnt_d  = bcnt;
    blink_d = blink;
    serve_d = serve_dir;
    win_d   = winner;
    unique case (state)
      IDLE: begin
        sl_d    = '0;
        sr_d    = '0;
        win_d   = 1'b0;
        blink_d = 1'b1;
        if (start) state_d = PLAY;
      end
      PLAY: begin
        if (point_left && point_right) begin
          state_d = PAUSE;
          pcnt_d  = PF;
        end else if (point_left || point_right) begin
          sl_d    = point_left && score_left < WIN ? score_left + 4'd1 : score_left;
          sr_d    = point_right && score_right < WIN ? score_right + 4'd1 : score_right;
          serve_d = point_left;
          pcnt_d  = PF;
          state_d = PAUSE;
          if (sl_d == WIN || sr_d == WIN) begin
            state_d = OVER;
            win_d   = point_right;
            bcnt_d  = BF;
            blink_d = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (frame_tick) begin
          pcnt_d = pcnt - {7'd0, pcnt != 8'd0};
          if (pcnt <= 8'd1) state_d = PLAY;
        end
      end
      OVER: begin
        // edge-qualified so a start held since the winning point cannot restart
        if (start && !start_q) begin
          state_d = IDLE;
          sl_d    = '0;
          sr_d    = '0;
          win_d   = 1'b0;
          blink_d = 1'b1;
          bcnt_d  = '0;
        end else if (frame_tick) begin
          bcnt_d  = bcnt <= 8'd1 ? BF : bcnt - 8'd1;
          blink_d = bcnt <= 8'd1 ? !blink : blink;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: random and directed stimulus checked against a frame-count model of the match rules
module tb_score_keeper;
  localparam int WIN = 9, PF = 60, BF = 30;
  logic clk = 0, reset = 1, frame_tick = 0, start = 0, point_left = 0, point_right = 0;
  logic [3:0] score_left, score_right;
  logic show_left, show_right, play_en, serve_dir, game_over, winner;
  int checks = 0, failures = 0;
  score_keeper #(.WIN_SCORE(WIN), .PAUSE_FRAMES(PF), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .point_left(point_left), .point_right(point_right),
    .score_left(score_left), .score_right(score_right),
    .show_left(show_left), .show_right(show_right), .play_en(play_en),
    .serve_dir(serve_dir), .game_over(game_over), .winner(winner));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // model: mode 0 idle, 1 playing, 2 frozen, 3 match over; ticks counts frames since freeze/over began
  int m_mode = 0, ml = 0, mr = 0, ticks = 0;
  logic mserve = 0, mwin = 0, prev_start = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; ml = 0; mr = 0; ticks = 0; mserve = 0; mwin = 0; prev_start = 0;
    end else begin
      case (m_mode)
        0: if (start) m_mode = 1;
        1: if (point_left && point_right) begin m_mode = 2; ticks = 0; end
           else if (point_left || point_right) begin
             if (point_left) ml++; else mr++;
             mserve = point_left;
             ticks = 0;
             if (ml == WIN || mr == WIN) begin m_mode = 3; mwin = point_right; end
             else m_mode = 2;
           end
        2: if (frame_tick) begin ticks++; if (ticks == PF) m_mode = 1; end
        3: if (start && !prev_start) begin m_mode = 0; ml = 0; mr = 0; mwin = 0; end
           else if (frame_tick) ticks++;
        default: m_mode = 0;
      endcase
      prev_start = start;
    end
  end
  always @(negedge clk) if (!reset) begin
    automatic bit vis = ((ticks / BF) % 2) == 0;
    chk("score_left", score_left, ml);
    chk("score_right", score_right, mr);
    chk("play_en", play_en, m_mode == 1);
    chk("game_over", game_over, m_mode == 3);
    chk("serve_dir", serve_dir, mserve);
    if (m_mode == 3) chk("winner", winner, mwin);
    chk("show_left", show_left, (m_mode == 3 && !mwin) ? vis : 1);
    chk("show_right", show_right, (m_mode == 3 && mwin) ? vis : 1);
  end
  task automatic cyc(input logic ft, input logic pl, input logic pr);
    frame_tick = ft; point_left = pl; point_right = pr;
    @(negedge clk);
    frame_tick = 0; point_left = 0; point_right = 0;
  endtask
  task automatic frames(input int n);
    repeat (n) begin cyc(1, 0, 0); cyc(0, 0, 0); end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_score_left", score_left, 0);
    chk("rst_show_left", show_left, 1);
    chk("rst_play_en", play_en, 0);
    start = 1; cyc(0, 0, 0); start = 0;
    chk("start_play_en", play_en, 1);
    cyc(0, 1, 0);
    chk("pt_score_left", score_left, 1);
    chk("pt_play_en", play_en, 0);
    chk("pt_serve_dir", serve_dir, 1);
    frames(PF - 1);
    chk("pause_59_play_en", play_en, 0);
    frames(1);
    chk("pause_60_play_en", play_en, 1);
    cyc(0, 1, 1);
    chk("both_score_left", score_left, 1);
    chk("both_score_right", score_right, 0);
    chk("both_play_en", play_en, 0);
    chk("both_serve_dir", serve_dir, 1);
    cyc(0, 0, 1);
    chk("pause_pr_score_right", score_right, 0);
    frames(PF);
    for (int i = 0; i < WIN; i++) begin
      if (i == WIN - 1) start = 1;
      cyc(0, 0, 1);
      if (i < WIN - 1) frames(PF);
    end
    chk("win_score_right", score_right, 9);
    chk("win_game_over", game_over, 1);
    chk("win_winner", winner, 1);
    chk("win_play_en", play_en, 0);
    frames(BF);
    chk("blink_show_right", show_right, 0);
    chk("blink_show_left", show_left, 1);
    chk("held_start_game_over", game_over, 1);
    frames(BF);
    chk("blink2_show_right", show_right, 1);
    start = 0; cyc(0, 0, 0);
    start = 1; cyc(0, 0, 0); start = 0;
    chk("restart_game_over", game_over, 0);
    chk("restart_score_right", score_right, 0);
    chk("restart_play_en", play_en, 0);
    cyc(0, 0, 1);
    chk("idle_pr_score_right", score_right, 0);
    start = 1; cyc(0, 0, 0); start = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0);
      if (i < 2) frames(PF);
    end
    frames(5);
    chk("pre_rst_score_left", score_left, 3);
    #2 reset = 1;
    #1;
    chk("arst_score_left", score_left, 0);
    chk("arst_serve_dir", serve_dir, 0);
    chk("arst_play_en", play_en, 0);
    chk("arst_show_left", show_left, 1);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("arst_idle_play_en", play_en, 0);
    repeat (20000) begin
      start = $urandom_range(0, 15) == 0;
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Match controller for the Pong scoreboard.
- Counts points for the left and right players.
- Freezes play for a fixed number of frames after each point.
- Detects the winning score and blinks the winner's digit.
- Drives the 4-bit number inputs and per-digit visibility of the two score renderers.
- Sits between the ball/collision logic (point pulses) and the GUI score digits.

Parameters:
WIN_SCORE, 9, score that ends the match; legal range 1..9 so the score fits one decimal digit
PAUSE_FRAMES, 60, frame ticks of freeze after a point (8-bit counter, 1..255)
BLINK_FRAMES, 30, frame ticks per blink half-period in GAME_OVER (8-bit counter, 1..255)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
frame_tick  input  1  one-cycle pulse per video frame (end of vsync)
start  input  1  level; start or restart request from button, already debounced
point_left  input  1  one-cycle pulse: left player scored
point_right  input  1  one-cycle pulse: right player scored
score_left  output  4  left score, 0..WIN_SCORE, to left score renderer number input
score_right  output  4  right score, 0..WIN_SCORE, to right score renderer number input
show_left  output  1  left digit visible
show_right  output  1  right digit visible
play_en  output  1  ball/paddle motion enabled
serve_dir  output  1  0 = serve toward left, 1 = serve toward right
game_over  output  1  match finished
winner  output  1  0 = left, 1 = right; valid only while game_over=1

Behaviour:
- All outputs are registered; there is no combinational path from input to output.
- FSM states: IDLE, PLAY, PAUSE, OVER. Reset forces IDLE immediately, asynchronously.
- Reset values: score_left=0, score_right=0, show_left=1, show_right=1, play_en=0, serve_dir=0, game_over=0, winner=0, pause/blink counters=0, blink phase=1 (visible).
- IDLE:
  - Scores are held at 0, play_en=0, both digits shown.
  - start=1 sampled on a clk edge -> PLAY next cycle, play_en=1.
- PLAY (play_en=1):
  - point_left alone -> score_left+1, serve_dir=1, pause counter loaded with PAUSE_FRAMES, play_en=0.
  - point_right alone -> score_right+1, serve_dir=0, pause counter loaded with PAUSE_FRAMES, play_en=0.
  - The updated score is visible on the cycle after the pulse.
  - If the new score equals WIN_SCORE, go -> OVER instead of PAUSE, with game_over=1 and winner set to the scorer.
  - point_left and point_right in the same cycle -> no score change; treated as a rally reset. Go -> PAUSE with serve_dir unchanged.
- PAUSE (play_en=0):
  - Each frame_tick decrements the pause counter.
  - The tick that brings the counter from 1 to 0 returns -> PLAY, with play_en=1 on the following cycle.
  - Point pulses in PAUSE, IDLE and OVER are ignored.
- OVER:
  - game_over=1; the loser's digit is steady on.
  - The winner's digit toggles visibility every BLINK_FRAMES frame_ticks, starting visible.
  - Scores are frozen.
  - A rising edge of start (previous sample 0, current sample 1) -> IDLE with scores cleared to 0, game_over=0, both digits shown.
  - A start held high from before entry to OVER must not restart the match; it must be released first.
- Arithmetic:
  - Scores are 4-bit unsigned and saturate at WIN_SCORE; they never exceed it.
  - Counters are 8-bit and loaded with the parameter value.
  - A frame_tick arriving in the same cycle as a load is ignored for that counter.
- reset asserted mid-PAUSE or mid-OVER: all state returns to reset values at once; counters clear.

Test Plan:
- Reset, start=1 for 1 cycle, then point_left pulse -> score_left=1 next cycle, play_en=0, serve_dir=1; after PAUSE_FRAMES=60 frame_ticks, play_en=1.
- In PLAY, point_left and point_right in the same cycle -> scores unchanged, PAUSE entered, serve_dir unchanged.
- point_right pulses during PAUSE and in IDLE -> score_right unchanged.
- 9 point_right pulses, each separated by full pauses -> score_right=9, game_over=1, winner=1, play_en=0; show_right toggles every 30 frame_ticks, show_left stays 1.
- In OVER with start held high since entry -> no restart; release start, then assert it -> IDLE, both scores 0, game_over=0.
- Assert reset during PAUSE with score_left=3 -> all outputs at reset values immediately, without a clk edge; FSM in IDLE.
